// File: rtl/audio_pkg.sv
// Shared types and helpers for the playback gain stage: ramp FSM states,
// channel geometry and the 16-bit saturating clamp.
package audio_pkg;

    typedef enum logic [1:0] {
        PASS      = 2'd0,
        RAMP_DOWN = 2'd1,
        MUTED     = 2'd2,
        RAMP_UP   = 2'd3
    } mute_state_e;

    localparam logic [15:0] UNITY_GAIN = 16'h4000;
    localparam int NUM_CH   = 2;
    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 48;

    typedef struct packed {
        logic                    sat;
        logic [SAMPLE_W-1:0]     val;
    } sat16_t;

    // Clamp an already rounded and scaled value to the signed 16-bit range.
    function automatic sat16_t sat16(input logic signed [ACC_W-1:0] r);
        sat16_t res;
        if (r > 48'sd32767) begin
            res.sat = 1'b1;
            res.val = 16'h7FFF;
        end else if (r < -48'sd32768) begin
            res.sat = 1'b1;
            res.val = 16'h8000;
        end else begin
            res.sat = 1'b0;
            res.val = r[SAMPLE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/gain_ramp.sv
// Soft mute/unmute ramp: steps the per-channel effective gain once per
// accepted sample towards either silence or the target gain.
module gain_ramp
    import audio_pkg::*;
#(
    parameter int                NUM_CH    = 2,
    parameter int                GAIN_W    = 16,
    parameter logic [GAIN_W-1:0] RAMP_STEP = 'h40
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             step,
    input  logic                             soft_mute,
    input  logic [NUM_CH-1:0][GAIN_W-1:0]    target,
    output logic [NUM_CH-1:0][GAIN_W-1:0]    eff,
    output logic [1:0]                       state
);

    mute_state_e                      state_q, state_d;
    logic [NUM_CH-1:0][GAIN_W-1:0]    eff_q, eff_d;
    logic [NUM_CH-1:0][GAIN_W-1:0]    cur, dn, tw;
    logic                             go_dn, go_up;

    // cur is the gain applied to the sample being accepted right now.
    always_comb begin
        cur = '0;
        dn  = '0;
        tw  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (state_q)
                PASS:    cur[i] = target[i];
                MUTED:   cur[i] = '0;
                default: cur[i] = eff_q[i];
            endcase
            dn[i] = (cur[i] > RAMP_STEP) ? cur[i] - RAMP_STEP : '0;
            if (cur[i] <= target[i])
                tw[i] = (target[i] - cur[i] > RAMP_STEP) ? cur[i] + RAMP_STEP : target[i];
            else
                tw[i] = (cur[i] - target[i] > RAMP_STEP) ? cur[i] - RAMP_STEP : target[i];
        end
    end

    always_comb begin
        state_d = state_q;
        eff_d   = eff_q;
        go_dn   = 1'b0;
        go_up   = 1'b0;
        if (step) begin
            case (state_q)
                PASS:    go_dn = soft_mute;
                MUTED:   go_up = !soft_mute;
                default: begin
                    go_dn = soft_mute;
                    go_up = !soft_mute;
                end
            endcase
        end
        if (go_dn) begin
            eff_d   = dn;
            state_d = (dn == '0) ? MUTED : RAMP_DOWN;
        end else if (go_up) begin
            eff_d   = tw;
            state_d = (tw == target) ? PASS : RAMP_UP;
        end
    end

    // Power-up fades in from silence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RAMP_UP;
            eff_q   <= '0;
        end else begin
            state_q <= state_d;
            eff_q   <= eff_d;
        end
    end

    assign eff   = cur;
    assign state = state_q;

endmodule

// File: rtl/audio_gain_stage.sv
// Two-stage AXI-Stream stereo gain: S1 multiplies by the effective gain,
// S2 rounds, saturates and counts clamped channel-samples.
module audio_gain_stage
    import audio_pkg::*;
#(
    parameter int                GAIN_W    = 16,
    parameter logic [GAIN_W-1:0] RAMP_STEP = 16'h0040,
    parameter int                SATCNT_W  = 16
) (
    input  logic                axi_clk,
    input  logic                axis_aresetn,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [32:0]         s_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [32:0]         m_axis_tdata,
    input  logic [GAIN_W-1:0]   gain_l,
    input  logic [GAIN_W-1:0]   gain_r,
    input  logic                soft_mute,
    input  logic                sat_clear,
    output logic [1:0]          mute_state,
    output logic [SATCNT_W-1:0] sat_count
);

    localparam int STAGES = 2;
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int FRAC   = GAIN_W - 2;
    localparam int NSAT_W = $clog2(NUM_CH + 1);
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC - 1);

    logic [STAGES:1]                       vld_pipe;
    logic                                  run;
    logic                                  adv1, adv2, accept, s2_load;
    logic [NUM_CH-1:0][GAIN_W-1:0]         target, eff;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]       out_data;
    logic [NUM_CH-1:0]                     sat_hit;
    logic [NSAT_W-1:0]                     n_sat;
    logic [SATCNT_W:0]                     sat_sum;
    logic                                  unused_ok;

    assign unused_ok = s_axis_tdata[32];

    // Holds the input closed while reset is asserted.
    always_ff @(posedge axi_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) run <= 1'b0;
        else               run <= 1'b1;
    end

    assign adv2          = !vld_pipe[2] | m_axis_tready;
    assign adv1          = !vld_pipe[1] | adv2;
    assign s_axis_tready = run & adv1;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign s2_load       = adv2 & vld_pipe[1];

    always_ff @(posedge axi_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            vld_pipe <= '0;
        end else begin
            if (adv1) vld_pipe[1] <= accept;
            if (adv2) vld_pipe[2] <= vld_pipe[1];
        end
    end

    assign target = {gain_r, gain_l};

    gain_ramp #(
        .NUM_CH    (NUM_CH),
        .GAIN_W    (GAIN_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .clk       (axi_clk),
        .rst_n     (axis_aresetn),
        .step      (accept),
        .soft_mute (soft_mute),
        .target    (target),
        .eff       (eff),
        .state     (mute_state)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [SAMPLE_W-1:0] x;
        logic signed [GAIN_W:0]     g;
        logic signed [PROD_W-1:0]   prod_q;
        logic signed [ACC_W-1:0]    rnd;
        sat16_t                     res;
        logic [SAMPLE_W-1:0]        out_q;

        assign x   = s_axis_tdata[c*SAMPLE_W +: SAMPLE_W];
        assign g   = {1'b0, eff[c]};
        assign rnd = (ACC_W'(prod_q) + RND_HALF) >>> FRAC;
        assign res = sat16(rnd);

        always_ff @(posedge axi_clk or negedge axis_aresetn) begin
            if (!axis_aresetn)  prod_q <= '0;
            else if (accept)    prod_q <= PROD_W'(x) * PROD_W'(g);
        end

        always_ff @(posedge axi_clk or negedge axis_aresetn) begin
            if (!axis_aresetn)  out_q <= '0;
            else if (s2_load)   out_q <= res.val;
        end

        assign out_data[c] = out_q;
        assign sat_hit[c]  = res.sat;
    end

    // Clamp events are counted as the sample lands in S2; clear has priority.
    assign n_sat   = s2_load ? NSAT_W'($countones(sat_hit)) : '0;
    assign sat_sum = {1'b0, sat_count} + (SATCNT_W+1)'(n_sat);

    always_ff @(posedge axi_clk or negedge axis_aresetn) begin
        if (!axis_aresetn)          sat_count <= '0;
        else if (sat_clear)         sat_count <= '0;
        else if (sat_sum[SATCNT_W]) sat_count <= '1;
        else                        sat_count <= sat_sum[SATCNT_W-1:0];
    end

    assign m_axis_tvalid = vld_pipe[2];
    assign m_axis_tdata  = {1'b0, out_data};

endmodule
